// File: rtl/mac_pkg.sv
// Shared types, default widths and saturation helpers for the MAC result path.
package mac_pkg;

  localparam int unsigned NUM_PE      = 8;
  localparam int unsigned ACC_WIDTH   = 32;
  localparam int unsigned OUT_WIDTH   = 8;
  localparam int unsigned SHIFT_WIDTH = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Largest representable value of a w-bit signed number.
  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest representable value of a w-bit signed number.
  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational rounding right-shift plus signed saturation for one accumulator lane.
module requant_sat
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  output logic signed [OUT_W-1:0]   data_c,
  output logic                      clip_c
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(sat_max(OUT_W));
  localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(sat_min(OUT_W));

  int unsigned              s_eff;
  logic signed [EXT_W-1:0]  acc_ext;
  logic signed [EXT_W-1:0]  rnd;
  logic signed [EXT_W-1:0]  sum;
  logic signed [EXT_W-1:0]  res;

  // One extra bit keeps acc + half-LSB from overflowing before the shift.
  always_comb begin
    s_eff   = (32'(shift_i) > ACC_W - 1) ? ACC_W - 1 : 32'(shift_i);
    acc_ext = {acc_i[ACC_W-1], acc_i};
    rnd     = (s_eff == 0) ? '0 : (EXT_W'(1) <<< (s_eff - 1));
    sum     = acc_ext + rnd;
    res     = sum >>> s_eff;
    clip_c  = 1'b0;
    data_c  = OUT_W'(res);
    if (res > MAX_V) begin
      data_c = OUT_W'(MAX_V);
      clip_c = 1'b1;
    end else if (res < MIN_V) begin
      data_c = OUT_W'(MIN_V);
      clip_c = 1'b1;
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// Captures a tile of MAC accumulators and streams requantized lanes out one per beat.
// Optional DRAIN_SAT_CNT_EN adds a per-drain saturation counter port.
module mac_result_drain #(
  parameter int unsigned NUM_PE      = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 8,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          acc_valid,
  input  logic [NUM_PE*ACC_WIDTH-1:0]   acc_data,
  input  logic [SHIFT_WIDTH-1:0]        shift_amt,
  output logic                          acc_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_last,
  output logic                          busy
`ifdef DRAIN_SAT_CNT_EN
  ,
  output logic [15:0]                   sat_count
`endif
);

  import mac_pkg::*;

  localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  drain_state_t                  state_q, state_d;
  logic [NUM_PE*ACC_WIDTH-1:0]   bank_q, bank_d;
  logic [SHIFT_WIDTH-1:0]        shift_q, shift_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                          out_last_q, out_last_d;
  logic                          out_valid_q, out_valid_d;
  logic                          acc_ready_q, acc_ready_d;
  logic                          busy_q, busy_d;
  logic                          clip_q, clip_d;
`ifdef DRAIN_SAT_CNT_EN
  logic [15:0]                   sat_q, sat_d;
`endif

  logic [IDX_W-1:0]              idx_nxt;
  logic signed [ACC_WIDTH-1:0]   sel_acc;
  logic [SHIFT_WIDTH-1:0]        sel_shift;
  logic signed [OUT_WIDTH-1:0]   rq_data_c;
  logic                          rq_clip_c;
  logic                          hs;

  // In IDLE the requantizer looks at incoming lane 0 so it can be registered at capture;
  // in DRAIN it looks one lane ahead so the next beat is ready on the handshake edge.
  always_comb begin
    idx_nxt   = idx_q + IDX_W'(1);
    sel_acc   = (state_q == IDLE) ? acc_data[ACC_WIDTH-1:0]
                                  : bank_q[idx_nxt*ACC_WIDTH +: ACC_WIDTH];
    sel_shift = (state_q == IDLE) ? shift_amt : shift_q;
  end

  requant_sat #(
    .ACC_W   (ACC_WIDTH),
    .OUT_W   (OUT_WIDTH),
    .SHIFT_W (SHIFT_WIDTH)
  ) u_requant_sat (
    .acc_i   (sel_acc),
    .shift_i (sel_shift),
    .data_c  (rq_data_c),
    .clip_c  (rq_clip_c)
  );

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    clip_d     = clip_q;
`ifdef DRAIN_SAT_CNT_EN
    sat_d      = sat_q;
`endif
    hs         = out_valid_q & out_ready;

    case (state_q)
      IDLE: begin
        if (acc_valid) begin
          state_d    = DRAIN;
          bank_d     = acc_data;
          shift_d    = shift_amt;
          idx_d      = '0;
          out_data_d = rq_data_c;
          clip_d     = rq_clip_c;
          out_last_d = (NUM_PE == 1);
`ifdef DRAIN_SAT_CNT_EN
          sat_d      = '0;
`endif
        end
      end
      DRAIN: begin
        if (hs) begin
`ifdef DRAIN_SAT_CNT_EN
          if (clip_q && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
`endif
          if (out_last_q) begin
            state_d    = IDLE;
            out_data_d = '0;
            out_last_d = 1'b0;
            clip_d     = 1'b0;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = rq_data_c;
            clip_d     = rq_clip_c;
            out_last_d = (idx_nxt == IDX_W'(NUM_PE - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d == DRAIN);
    acc_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      bank_q      <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      clip_q      <= 1'b0;
`ifdef DRAIN_SAT_CNT_EN
      sat_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      acc_ready_q <= acc_ready_d;
      busy_q      <= busy_d;
      clip_q      <= clip_d;
`ifdef DRAIN_SAT_CNT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign acc_ready = acc_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
`ifdef DRAIN_SAT_CNT_EN
  assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: directed rounding/saturation/backpressure/reset cases plus random drains.
module tb_mac_result_drain;

  localparam int NPE = 8;

  logic                   clk = 1'b0;
  logic                   srst;
  logic                   acc_valid;
  logic [NPE*32-1:0]      acc_data;
  logic [4:0]             shift_amt;
  logic                   acc_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [7:0]      out_data;
  logic                   out_last;
  logic                   busy;
`ifdef DRAIN_SAT_CNT_EN
  logic [15:0]            sat_count;
`endif

  mac_result_drain dut (
    .clk       (clk),
    .srst      (srst),
    .acc_valid (acc_valid),
    .acc_data  (acc_data),
    .shift_amt (shift_amt),
    .acc_ready (acc_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef DRAIN_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]         sb[$];
  logic signed [31:0] lane_v[NPE];
  int                 exp_sat;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference requantizer in 64-bit arithmetic.
  function automatic longint ref_rq(input logic signed [31:0] a, input int sh, output bit clip);
    longint v;
    int s;
    v    = longint'(a);
    s    = (sh > 31) ? 31 : sh;
    clip = 1'b0;
    if (s > 0) v = (v + (longint'(1) <<< (s - 1))) >>> s;
    if (v > 127) begin v = 127; clip = 1'b1; end
    else if (v < -128) begin v = -128; clip = 1'b1; end
    return v;
  endfunction

  // Monitor: scoreboard compare on handshakes and stability during stalls.
  logic              stall_prev = 1'b0;
  logic signed [7:0] prev_data;
  logic              prev_last;
  always @(negedge clk) begin
    logic [8:0] e;
    if (srst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check_eq("stall_data", out_data, prev_data);
        check_eq("stall_last", out_last, prev_last);
      end
      if (stall_prev) check_eq("stall_valid", out_valid, 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check_eq("sb_depth", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check_eq("beat_data", out_data, $signed(e[7:0]));
          check_eq("beat_last", out_last, e[8]);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Called at #1 after an edge with the block idle; returns #1 after the capture edge.
  task automatic do_capture(input int sh);
    bit   c;
    longint v;
    exp_sat = 0;
    for (int i = 0; i < NPE; i++) begin
      acc_data[i*32 +: 32] = lane_v[i];
      v = ref_rq(lane_v[i], sh, c);
      if (c) exp_sat++;
      sb.push_back({(i == NPE - 1), 8'(v)});
    end
    shift_amt = 5'(sh);
    acc_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
    check_eq("cap_valid", out_valid, 1);
  endtask

  task automatic drain_all(input bit rnd_ready);
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      if (sb.size() == 0 && acc_ready) done = 1'b1;
    end
    check_eq("drain_done", done, 1);
    check_eq("idle_valid", out_valid, 0);
`ifdef DRAIN_SAT_CNT_EN
    check_eq("sat_count", sat_count, exp_sat);
`endif
  endtask

  initial begin
    srst = 1'b1; acc_valid = 1'b0; acc_data = '0; shift_amt = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    check_eq("rst_acc_ready", acc_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_data", out_data, 0);

    // Basic drain with exact cycle timing.
    for (int i = 0; i < NPE; i++) lane_v[i] = 32'(i);
    out_ready = 1'b1;
    do_capture(0);
    check_eq("basic_busy", busy, 1);
    check_eq("basic_acc_ready", acc_ready, 0);
    repeat (7) @(posedge clk);
    #1;
    check_eq("basic_lane7_valid", out_valid, 1);
    check_eq("basic_lane7_last", out_last, 1);
    @(posedge clk);
    #1;
    check_eq("basic_end_valid", out_valid, 0);
    check_eq("basic_end_ready", acc_ready, 1);
    check_eq("basic_sb_empty", sb.size(), 0);

    // Rounding cases.
    lane_v = '{-3, 5, 6, -6, 1, -1, 2, -2};
    do_capture(1);
    drain_all(1'b0);
    lane_v = '{6, -6, 5, -5, 7, 2, -2, 1};
    do_capture(2);
    drain_all(1'b0);
    lane_v = '{32'h7FFFFFFF, 32'h80000000, 32'h40000000, 32'hC0000000, 0, 1, -1, 32'h3FFFFFFF};
    do_capture(31);
    drain_all(1'b0);

    // Saturation, including the exact bounds.
    lane_v = '{1000, -1000, 127, -128, 128, -129, 0, 5};
    do_capture(0);
    drain_all(1'b0);

    // Backpressure 1,0,1,0 with a mid-drain acc_valid pulse that must be ignored.
    for (int i = 0; i < NPE; i++) lane_v[i] = 32'((i + 1) * 300 - 1200);
    out_ready = 1'b1;
    do_capture(3);
    for (int k = 0; k < 15; k++) begin
      out_ready = (k % 2 == 0);
      if (k == 4) begin
        acc_valid = 1'b1;
        acc_data  = {NPE{32'h0000_0055}};
        check_eq("bp_acc_ready", acc_ready, 0);
      end
      if (k == 6) acc_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    check_eq("bp_end_valid", out_valid, 0);
    check_eq("bp_end_ready", acc_ready, 1);
    check_eq("bp_sb_empty", sb.size(), 0);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("bp_no_capture", out_valid, 0);

    // Reset after three accepted beats, then a clean drain from lane 0.
    for (int i = 0; i < NPE; i++) lane_v[i] = 32'(i * 20 - 70);
    out_ready = 1'b1;
    do_capture(0);
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    sb.delete();
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_ready", acc_ready, 1);
    check_eq("mid_rst_busy", busy, 0);
    for (int i = 0; i < NPE; i++) lane_v[i] = 32'(100 - i * 9);
    do_capture(1);
    drain_all(1'b0);

    // Random tiles with random backpressure.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NPE; i++) lane_v[i] = 32'($urandom());
      do_capture(int'($urandom_range(0, 31)));
      drain_all(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Downstream stage of `mac_top`. When the MAC array finishes a tile, this block captures the `NUM_PE` accumulator results in one cycle and requantizes each one with a rounding right-shift and signed saturation. It then streams the results out one lane per beat over a valid/ready interface to the writeback buffer. It frees the MAC array for the next tile as soon as capture completes.

## Interface
Parameters:
- `NUM_PE`, 8, number of accumulator lanes captured per tile.
- `ACC_WIDTH`, 32, signed accumulator width per lane.
- `OUT_WIDTH`, 8, signed output width per beat.
- `SHIFT_WIDTH`, 5, width of the requantization shift amount.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all logic on rising edge.
- `srst` in 1: synchronous active-high reset.
- `acc_valid` in 1: accumulator bank valid; driven by `processing_done` of `mac_top`.
- `acc_data` in `NUM_PE*ACC_WIDTH`: lane i at bits `[i*ACC_WIDTH +: ACC_WIDTH]`, signed.
- `shift_amt` in `SHIFT_WIDTH`: right-shift amount, sampled at capture.
- `acc_ready` out 1: block can capture a bank.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_data` out `OUT_WIDTH`: requantized lane, signed.
- `out_last` out 1: marks lane `NUM_PE-1`.
- `busy` out 1: drain in progress.

## Operation
- Two states, IDLE and DRAIN. Reset enters IDLE.
- **IDLE:**
  - `acc_ready`=1.
  - On `acc_valid & acc_ready`, register all lanes and `shift_amt`, set lane index to 0, go to DRAIN.
- **DRAIN:**
  - `acc_ready`=0 and `busy`=1.
  - Present the requantized lane `idx` on `out_data`.
  - A handshake is `out_valid & out_ready`. Each handshake increments `idx`.
  - The handshake on lane `NUM_PE-1` (`out_last`=1) returns the block to IDLE.
- **`acc_valid` in DRAIN:** no handshake and no effect. The producer holds `acc_valid` until `acc_ready`.
- **Requantization, per lane, signed arithmetic with `ACC_WIDTH+1` bits of headroom:**
  - Clamp the effective shift s to `min(shift_amt, ACC_WIDTH-1)`.
  - If s>0: r = (acc + (1<<(s-1))) >>> s. If s=0: r = acc.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- **Output stability:**
  - While `out_valid=1 & out_ready=0`, `out_data` and `out_last` stay stable.
  - `out_valid` never drops without a handshake.
- **`srst` mid-drain:** discard captured data, return to IDLE, no further beats.

## Timing
- **Reset values:**
  - `acc_ready`=1.
  - `out_valid`=0.
  - `out_data`=0.
  - `out_last`=0.
  - `busy`=0.
  - `sat_count`=0 when present.
- **Capture:** the handshake at edge N makes `out_valid`=1 with lane 0 in the cycle after edge N.
- **Throughput:** one beat per cycle while `out_ready`=1. With `out_ready` held high, `NUM_PE` beats occupy `NUM_PE` consecutive cycles.
- **Drain end:**
  - After the final handshake edge, `out_valid`=0 and `acc_ready`=1 in the next cycle.
  - Minimum capture-to-capture spacing is `NUM_PE+1` cycles.
- **Output registers:** `out_data` and `out_last` are registered. There is no combinational path from `out_ready` to `out_data`. `out_valid` depends only on state.

## Configuration
- **`DRAIN_SAT_CNT_EN` defined:**
  - Adds output port `sat_count`, 16 bits.
  - Counts beats whose value was clipped by saturation during the current drain.
  - Cleared to 0 at capture.
  - Saturates at 16'hFFFF.
  - A clipped beat is counted once, on its handshake.
- **`DRAIN_SAT_CNT_EN` undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Shared package `mac_pkg`:**
  - State enum `drain_state_t` (IDLE, DRAIN).
  - Default widths `NUM_PE`, `ACC_WIDTH`, `OUT_WIDTH`.
  - Saturation bounds as functions of `OUT_WIDTH`.
- **Sub-module `requant_sat`:** combinational round, shift and saturate for one lane. It outputs the value and a clip flag, and is instantiated once on the selected lane.

## Test plan
- **Reset:** hold `srst` 3 cycles → `acc_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0.
- **Basic drain:** lanes 0..7 = 0..7, `shift_amt`=0, `out_ready`=1, capture at edge N → beats 0,1,…,7 in cycles N+1..N+8; `out_last` only on 7; `acc_ready`=1 at N+9.
- **Rounding:** `shift_amt`=1 with acc -3 → -1 and acc 5 → 3; `shift_amt`=2 with acc 6 → 2; `shift_amt`=31 with acc 32'h7FFFFFFF → 1.
- **Saturation:** `shift_amt`=0 with lanes 1000, -1000, 127, -128 → 127, -128, 127, -128; with `DRAIN_SAT_CNT_EN` defined, `sat_count`=2.
- **Backpressure:** `out_ready` pattern 1,0,1,0… → 8 beats in 16 cycles, `out_data` stable during stalls, `acc_valid` pulsed mid-drain ignored (`acc_ready`=0).
- **Reset mid-drain:** `srst` after 3 accepted beats → `out_valid`=0 next cycle and `acc_ready`=1; a new capture then drains starting at lane 0.
